fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Front-end PC generator and instruction-fetch sequencer; it is the consumer end of the execute-stage redirect interface (need_jump / pre_pc).
- Issues one-outstanding-request fetches to instruction memory and presents {pc, instr, pre_pc} to the regD pipeline register with a valid/ready handshake.
- On a redirect from execute, it restarts fetch at the new target and squashes all stale in-flight work.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
- INSTR_W, 32, instruction word width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- execute_i_need_jump  in  1  redirect request from execute, valid for one cycle
- execute_i_pre_pc  in  64  redirect target from execute
- imem_o_req  out  1  fetch request valid
- imem_o_addr  out  64  fetch address, 4-byte aligned
- imem_i_gnt  in  1  memory accepts the request this cycle (req && gnt = handshake)
- imem_i_rvalid  in  1  response valid, exactly one per granted request, at least 1 cycle after gnt
- imem_i_rdata  in  INSTR_W  response instruction
- fetch_o_valid  out  1  fetched instruction valid toward regD
- fetch_o_pc  out  64  PC of the presented instruction
- fetch_o_instr  out  INSTR_W  presented instruction
- fetch_o_pre_pc  out  64  predicted next PC (fetch_o_pc + 4)
- fetch_i_ready  in  1  regD accepts (valid && ready = transfer)
- fetch_o_flush  out  1  one-cycle squash pulse to regD/regE

Behaviour:
- Reset (rst=1 at edge): state=REQ, pc_q=RESET_PC, imem_o_req=0, fetch_o_valid=0, fetch_o_flush=0, fetch_o_pc=0, fetch_o_instr=0, fetch_o_pre_pc=0. Reset mid-transaction abandons the outstanding request; any rvalid arriving in the first cycle after reset is ignored. imem_o_req first asserts in the cycle after rst deasserts.
- States: REQ, WAIT, HOLD, DROP.
- REQ: imem_o_req=1, imem_o_addr=pc_q. On gnt -> WAIT. req and addr hold stable until gnt.
- WAIT: req=0. On rvalid -> latch rdata, pc_q into the output regs; fetch_o_valid=1 next cycle; pc_q += 4 -> HOLD.
- HOLD: present the output. On valid && ready: if the next request has not been issued yet -> REQ. Zero-bubble option: REQ may run concurrently with HOLD, with fetch_o_valid cleared on transfer. Throughput is 1 instr per 2 cycles minimum with a 1-cycle memory.
- Redirect (need_jump=1), highest priority, in any state:
  - pc_q <= {pre_pc[63:2], 2'b00}.
  - fetch_o_valid <= 0; fetch_o_flush=1 for exactly that cycle (combinational from need_jump).
  - If a request is granted but its response is not yet returned (WAIT, or REQ with gnt that same cycle) -> DROP. Otherwise -> REQ.
- Redirect coincident with rvalid in WAIT: the response is discarded -> REQ.
- Redirect coincident with a transfer (valid && ready): the transfer still completes at regD; regD is flushed by fetch_o_flush.
- DROP: req=0. On rvalid, discard the data -> REQ. A second redirect in DROP updates pc_q and stays in DROP.
- Redirect while in REQ without gnt: the address changes next cycle. This is the only permitted mid-request address change.
- Arithmetic: pc + 4 wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0); no trap.
- fetch_o_pre_pc = fetch_o_pc + 4, registered together with fetch_o_pc.
- Invariant: at most one granted request is outstanding.

Test Plan:
- Reset release, gnt=1 immediately, rvalid 1 cycle later with rdata=32'h00000013 -> imem_o_addr=0x80000000, then fetch_o_valid=1, pc=0x80000000, instr=0x13, pre_pc=0x80000004.
- fetch_i_ready=0 for 5 cycles while valid -> outputs held stable, no new request while HOLD; on ready=1 the next request is issued at addr 0x80000004.
- Redirect to 0x80001003 while in WAIT -> flush pulse for 1 cycle, stale rvalid data 0xDEADBEEF never presented, next request addr=0x80001000.
- Redirect coincident with rvalid -> response dropped, next request addr = target, no extra rvalid awaited.
- gnt held low for 3 cycles, redirect in cycle 2 -> addr switches to the target; no transaction to the old addr completes.
- pc_q = 0xFFFFFFFFFFFFFFFC fetched -> next addr 0x0; rst asserted during WAIT -> outputs zero, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Front-end PC generator: one-outstanding fetch sequencer toward imem, valid/ready
// presentation to regD, and redirect handling that squashes stale in-flight responses.
`timescale 1ns/1ps
module fetch_pc_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               execute_i_need_jump,
  input  logic [63:0]        execute_i_pre_pc,
  output logic               imem_o_req,
  output logic [63:0]        imem_o_addr,
  input  logic               imem_i_gnt,
  input  logic               imem_i_rvalid,
  input  logic [INSTR_W-1:0] imem_i_rdata,
  output logic               fetch_o_valid,
  output logic [63:0]        fetch_o_pc,
  output logic [INSTR_W-1:0] fetch_o_instr,
  output logic [63:0]        fetch_o_pre_pc,
  input  logic               fetch_i_ready,
  output logic               fetch_o_flush
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_e;

  state_e             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               alive_q;
  logic               vld_q, vld_d;
  logic [63:0]        opc_q, opc_d;
  logic [INSTR_W-1:0] oinstr_q, oinstr_d;
  logic [63:0]        opre_q, opre_d;
  logic               req;
  logic               load;
  logic               in_flight;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    vld_d     = vld_q;
    opc_d     = opc_q;
    oinstr_d  = oinstr_q;
    opre_d    = opre_q;
    req       = 1'b0;
    load      = 1'b0;
    in_flight = 1'b0;

    case (state_q)
      REQ: begin
        // alive_q keeps the request low for the first cycle out of reset
        req = alive_q;
        if (alive_q && imem_i_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_i_rvalid) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Next fetch is issued in the same cycle the presented word is taken
        if (fetch_i_ready) begin
          req     = 1'b1;
          vld_d   = 1'b0;
          state_d = imem_i_gnt ? WAIT : REQ;
        end
      end
      DROP: begin
        if (imem_i_rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    if (load && !execute_i_need_jump) begin
      vld_d    = 1'b1;
      opc_d    = pc_q;
      oinstr_d = imem_i_rdata;
      opre_d   = pc_q + 64'd4;
      pc_d     = pc_q + 64'd4;
    end

    in_flight = (req && imem_i_gnt) ||
                (((state_q == WAIT) || (state_q == DROP)) && !imem_i_rvalid);

    if (execute_i_need_jump) begin
      pc_d    = execute_i_pre_pc & ~64'h3;
      vld_d   = 1'b0;
      state_d = in_flight ? DROP : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      alive_q  <= 1'b0;
      vld_q    <= 1'b0;
      opc_q    <= '0;
      oinstr_q <= '0;
      opre_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      alive_q  <= 1'b1;
      vld_q    <= vld_d;
      opc_q    <= opc_d;
      oinstr_q <= oinstr_d;
      opre_q   <= opre_d;
    end
  end

  assign imem_o_req     = req;
  assign imem_o_addr    = pc_q;
  assign fetch_o_valid  = vld_q;
  assign fetch_o_pc     = opc_q;
  assign fetch_o_instr  = oinstr_q;
  assign fetch_o_pre_pc = opre_q;
  assign fetch_o_flush  = execute_i_need_jump && !rst;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios followed by random traffic, all checked
// against a stream-level model of the expected PC sequence and a one-slot memory.
`timescale 1ns/1ps
module tb_fetch_pc_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        execute_i_need_jump = 1'b0;
  logic [63:0] execute_i_pre_pc = '0;
  logic        imem_o_req;
  logic [63:0] imem_o_addr;
  logic        imem_i_gnt = 1'b0;
  logic        imem_i_rvalid = 1'b0;
  logic [31:0] imem_i_rdata = '0;
  logic        fetch_o_valid;
  logic [63:0] fetch_o_pc;
  logic [31:0] fetch_o_instr;
  logic [63:0] fetch_o_pre_pc;
  logic        fetch_i_ready = 1'b0;
  logic        fetch_o_flush;

  fetch_pc_ctrl #(.RESET_PC(RESET_PC), .INSTR_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .execute_i_need_jump(execute_i_need_jump),
    .execute_i_pre_pc   (execute_i_pre_pc),
    .imem_o_req         (imem_o_req),
    .imem_o_addr        (imem_o_addr),
    .imem_i_gnt         (imem_i_gnt),
    .imem_i_rvalid      (imem_i_rvalid),
    .imem_i_rdata       (imem_i_rdata),
    .fetch_o_valid      (fetch_o_valid),
    .fetch_o_pc         (fetch_o_pc),
    .fetch_o_instr      (fetch_o_instr),
    .fetch_o_pre_pc     (fetch_o_pre_pc),
    .fetch_i_ready      (fetch_i_ready),
    .fetch_o_flush      (fetch_o_flush)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle drive values
  logic        d_rst = 1'b1, d_gnt = 1'b0, d_ready = 1'b0, d_jump = 1'b0, d_spur = 1'b0;
  logic [63:0] d_target = '0;
  int          d_lat = 1;

  // Reference state: next PC the instruction stream must deliver, plus one memory slot
  logic [63:0] exp_pc = RESET_PC;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          n_xfer = 0;

  logic        prev_req = 0, prev_gnt = 0, prev_jump = 0, prev_vld = 0, prev_ready = 0;
  logic [63:0] prev_addr = '0, prev_pc = '0;
  logic [31:0] prev_instr = '0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0000_0013;
    if (a == 64'h0000_0000_8000_0004) return 32'hDEAD_BEEF;
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    chk_eq("flush", fetch_o_flush, execute_i_need_jump);
    if (prev_jump) chk_eq("vld_after_jump", fetch_o_valid, 0);
    if (prev_req && !prev_gnt && !prev_jump) begin
      chk_eq("req_hold", imem_o_req, 1);
      chk_eq("addr_hold", imem_o_addr, prev_addr);
    end
    if (imem_o_req) chk_eq("addr_align", imem_o_addr[1:0], 0);
    if (prev_vld && !prev_ready && !prev_jump) begin
      chk_eq("vld_hold", fetch_o_valid, 1);
      chk_eq("pc_hold", fetch_o_pc, prev_pc);
      chk_eq("instr_hold", fetch_o_instr, prev_instr);
    end
    if (fetch_o_valid && !fetch_i_ready) chk_eq("no_req_in_hold", imem_o_req, 0);
    if (imem_i_rvalid) mem_busy = 1'b0;
    if (fetch_o_valid && fetch_i_ready) begin
      chk_eq("xfer_pc", fetch_o_pc, exp_pc);
      chk_eq("xfer_instr", fetch_o_instr, mem_word(fetch_o_pc));
      chk_eq("xfer_pre_pc", fetch_o_pre_pc, fetch_o_pc + 64'd4);
      exp_pc = fetch_o_pc + 64'd4;
      n_xfer++;
    end
    if (imem_o_req && imem_i_gnt) begin
      chk_eq("grant_addr", imem_o_addr, exp_pc);
      chk_eq("one_outstanding", mem_busy, 0);
      mem_busy = 1'b1;
      mem_cnt  = d_lat;
      mem_addr = imem_o_addr;
    end
    if (execute_i_need_jump) exp_pc = execute_i_pre_pc & ~64'h3;
    prev_req   = imem_o_req;
    prev_gnt   = imem_i_gnt;
    prev_jump  = execute_i_need_jump;
    prev_addr  = imem_o_addr;
    prev_vld   = fetch_o_valid;
    prev_ready = fetch_i_ready;
    prev_pc    = fetch_o_pc;
    prev_instr = fetch_o_instr;
  endtask

  task automatic step();
    @(negedge clk);
    rst           = d_rst;
    imem_i_rvalid = 1'b0;
    imem_i_rdata  = '0;
    if (!d_rst && mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_i_rvalid = 1'b1;
        imem_i_rdata  = mem_word(mem_addr);
      end
    end else if (!d_rst && d_spur) begin
      imem_i_rvalid = 1'b1;
      imem_i_rdata  = 32'h0BAD_0BAD;
    end
    imem_i_gnt          = d_gnt;
    fetch_i_ready       = d_ready;
    execute_i_need_jump = d_jump;
    execute_i_pre_pc    = d_target;
    #1;
    if (d_rst) begin
      mem_busy  = 1'b0;
      exp_pc    = RESET_PC;
      prev_req  = 0; prev_gnt = 0; prev_jump = 0; prev_vld = 0; prev_ready = 0;
    end else begin
      model_check();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk_eq("rst_req", imem_o_req, 0);
    chk_eq("rst_vld", fetch_o_valid, 0);
    chk_eq("rst_flush", fetch_o_flush, 0);
    chk_eq("rst_pc", fetch_o_pc, 0);
    chk_eq("rst_instr", fetch_o_instr, 0);
    chk_eq("rst_pre_pc", fetch_o_pre_pc, 0);

    d_rst = 0; d_spur = 1; step();
    chk_eq("first_cycle_req", imem_o_req, 0);
    d_spur = 0; d_gnt = 1; d_lat = 1; step();
    chk_eq("boot_req", imem_o_req, 1);
    chk_eq("boot_addr", imem_o_addr, 64'h8000_0000);
    d_gnt = 0; step();
    step();
    chk_eq("boot_vld", fetch_o_valid, 1);
    chk_eq("boot_pc", fetch_o_pc, 64'h8000_0000);
    chk_eq("boot_instr", fetch_o_instr, 32'h13);
    chk_eq("boot_pre_pc", fetch_o_pre_pc, 64'h8000_0004);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("stall_req", imem_o_req, 0);
    end
    d_ready = 1; d_gnt = 1; d_lat = 2; step();
    chk_eq("next_req", imem_o_req, 1);
    chk_eq("next_addr", imem_o_addr, 64'h8000_0004);

    d_ready = 0; d_gnt = 0; d_jump = 1; d_target = 64'h8000_1003; step();
    chk_eq("wait_flush", fetch_o_flush, 1);
    d_jump = 0; step();
    chk_eq("drop_flush", fetch_o_flush, 0);
    chk_eq("drop_req", imem_o_req, 0);
    chk_eq("drop_vld", fetch_o_valid, 0);
    d_gnt = 1; d_lat = 1; step();
    chk_eq("redir_addr", imem_o_addr, 64'h8000_1000);

    d_gnt = 0; d_jump = 1; d_target = 64'h8000_2000; step();
    chk_eq("rvalid_jump_flush", fetch_o_flush, 1);
    d_jump = 0; step();
    chk_eq("rvj_req", imem_o_req, 1);
    chk_eq("rvj_addr", imem_o_addr, 64'h8000_2000);
    chk_eq("rvj_vld", fetch_o_valid, 0);

    d_jump = 1; d_target = 64'h8000_3000; step();
    chk_eq("nogrant_old_addr", imem_o_addr, 64'h8000_2000);
    d_jump = 0; step();
    chk_eq("nogrant_new_addr", imem_o_addr, 64'h8000_3000);
    d_gnt = 1; step();
    d_gnt = 0; step();
    d_ready = 1; d_jump = 1; d_target = 64'hFFFF_FFFF_FFFF_FFFE; step();
    chk_eq("xj_vld", fetch_o_valid, 1);
    chk_eq("xj_pc", fetch_o_pc, 64'h8000_3000);
    d_ready = 0; d_jump = 0; d_gnt = 1; step();
    chk_eq("wrap_addr", imem_o_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_eq("wrap_vld", fetch_o_valid, 0);
    d_gnt = 0; step();
    d_ready = 1; d_gnt = 1; d_lat = 3; step();
    chk_eq("wrap_pc", fetch_o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_eq("wrap_pre_pc", fetch_o_pre_pc, 64'h0);
    chk_eq("wrap_next_addr", imem_o_addr, 64'h0);

    d_ready = 0; d_gnt = 0; step();
    chk_eq("wait_req", imem_o_req, 0);
    d_rst = 1; step(); step();
    chk_eq("midrst_req", imem_o_req, 0);
    chk_eq("midrst_vld", fetch_o_valid, 0);
    chk_eq("midrst_pc", fetch_o_pc, 0);
    chk_eq("midrst_instr", fetch_o_instr, 0);
    chk_eq("midrst_pre_pc", fetch_o_pre_pc, 0);
    d_rst = 0; d_spur = 1; step();
    chk_eq("midrst_first_req", imem_o_req, 0);
    d_spur = 0; d_gnt = 1; d_lat = 1; step();
    chk_eq("restart_addr", imem_o_addr, RESET_PC);

    for (int i = 0; i < 3000; i++) begin
      d_gnt   = ($urandom % 4) != 0;
      d_ready = ($urandom % 10) < 7;
      d_jump  = ($urandom % 12) == 0;
      d_lat   = $urandom_range(1, 3);
      case ($urandom % 4)
        0:       d_target = {$urandom, $urandom};
        1:       d_target = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
        default: d_target = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      endcase
      step();
    end
    chk_eq("progress", n_xfer > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
